display_scheduler: RTL and testbench
====================================

# display_scheduler

Sequencing controller for the five-digit decimal output display. It arbitrates between values written by the processor's output instruction and the 8-bit switch bank shown while the processor waits on an input instruction. It converts the selected binary value to five BCD digits with a multi-cycle shift-add-3 (double-dabble) engine and holds registered digits for the downstream 7-segment decoders. It replaces the combinational divide/modulo chain in the display path with a fixed-latency sequential datapath and a valid/ready handshake toward the processor.

## Interface
- `MAX_DEC`, default 99999: largest displayable value; anything above it shows the error code.
- `CONV_STEPS`, default 17: double-dabble iterations, since 2^17 > `MAX_DEC`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `out_valid` in 1: processor presents a value on `out_data`.
- `out_data` in 32: unsigned value to display.
- `out_ready` out 1: block accepts a value; high only in IDLE.
- `in_mode` in 1: processor is waiting for input; show the switches.
- `chaves` in 8: switch bank, unsigned.
- `busy` out 1: a conversion or commit is in progress.
- `done` out 1: one-cycle pulse after the digit registers update.
- `src` out 1: source of the displayed value; 0 = processor, 1 = switches.
- `dig1`..`dig5` out 4 each: BCD digits, `dig1` least significant. Code 14 = error, code 15 = blank.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- **IDLE:** `out_ready`=1, `busy`=0.
  - Priority 1, processor write: `out_valid`=1 completes the handshake. Latch `out_data`.
    - If `out_data` > `MAX_DEC`: set the err flag and go to COMMIT.
    - Otherwise: load the low 17 bits into the shift register, clear the 20-bit BCD accumulator, clear the step counter, set pending src=0, and go to CONV.
  - Priority 2, switch refresh: no handshake this cycle, `in_mode`=1, and either `src`=0 or `chaves` ≠ `sw_shown`.
    - Latch `chaves` into `sw_shown` and into the shift register (zero-extended), set pending src=1, and go to CONV.
    - The switch path never overflows.
  - Otherwise: stay in IDLE and hold the digits.
- **CONV:** one step per cycle.
  - Add 3 to each BCD nibble that is ≥ 5.
  - Shift {bcd, bin} left by 1.
  - Increment the counter.
  - After `CONV_STEPS` steps, go to COMMIT.
- **COMMIT:** one cycle.
  - Load `dig1`..`dig5` from the BCD nibbles, or all 14 if err.
  - Load `src` from pending src and clear err.
  - Assert `done` next cycle, then return to IDLE.
- When `in_mode` falls, the digits hold the switch value until the next processor write.
- While `busy`, `out_valid` is ignored and `out_ready`=0. The producer must hold `out_valid` and `out_data` stable until the handshake.
- Switch changes during CONV are picked up on the next IDLE evaluation, not mid-conversion.
- Arithmetic is unsigned. The compare against `MAX_DEC` uses the full 32 bits.

## Timing
- **Reset values** (asynchronous, while `rst_n`=0): state IDLE, `dig1`..`dig5`=15, `src`=0, `done`=0, `busy`=0, `out_ready`=1, `sw_shown`=0, err=0, counter=0.
- **Normal latency:** handshake sampled at edge E0. CONV steps occur at edges E1..E17. COMMIT runs in the cycle after E17. Digits change at E18, with `done`=1 and `out_ready`=1 from E18 to E19. The next handshake is possible at E19.
- **Overflow latency:** handshake at E0, COMMIT after E0, digits = 14 at E1, `done` high from E1 to E2.
- **Switch refresh:** same 18-cycle latency, measured from the IDLE edge that detects the change.
- `busy` = (state ≠ IDLE).
- `done` is registered and lasts exactly one cycle.
- Digits never change except at a COMMIT edge or at reset.
- **Reset mid-CONV:** the conversion is abandoned, the digits blank to 15, and there is no `done`.
- **Back-to-back writes:** throughput is 19 cycles per converted value and 2 cycles per overflow value.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle. All digits go to 15 immediately, `out_ready`=1, `busy`=0, `src`=0.
- **Normal write:** 12345 with a one-cycle valid. `dig5..dig1` = 1,2,3,4,5 exactly 18 edges after the handshake, `done` is a single pulse, `src`=0.
- **Boundaries:**
  - 99999 gives 9,9,9,9,9 after 18 edges.
  - 100000 gives all 14 one edge after the handshake.
  - 0 gives 0,0,0,0,0.
  - 0xFFFFFFFF gives all 14.
- **Switch mode:** `in_mode`=1, `chaves`=200 gives 0,0,2,0,0 with `src`=1. Then change `chaves` to 7, which gives 0,0,0,0,7 about 18 cycles later. Steady `chaves` triggers no further `done`.
- **Simultaneous events:** `out_valid`=1 with 42 while `in_mode`=1 and `chaves`=9 are new in the same IDLE cycle. 42 is displayed first with `src`=0, then 9 follows with `src`=1. `out_valid` held during CONV is not accepted until IDLE.
- **Reset mid-conversion:** handshake 54321, assert `rst_n`=0 at the 8th CONV edge. Digits stay 15 with no `done`. After release, a new write of 7 displays 0,0,0,0,7.

Source files
------------

// File: rtl/display_scheduler.sv
// Display sequencing controller: arbitrates between processor writes and the switch bank,
// converts the chosen value to five BCD digits with a sequential double-dabble engine.
module display_scheduler #(
  parameter int unsigned MAX_DEC    = 99999,
  parameter int unsigned CONV_STEPS = 17
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        out_valid_i,
  input  logic [31:0] out_data_i,
  output logic        out_ready_o,
  input  logic        in_mode_i,
  input  logic [7:0]  chaves_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        src_o,
  output logic [3:0]  dig1_o,
  output logic [3:0]  dig2_o,
  output logic [3:0]  dig3_o,
  output logic [3:0]  dig4_o,
  output logic [3:0]  dig5_o
);

  localparam int unsigned CntW = $clog2(CONV_STEPS + 1);

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e                state_q;
  logic [CONV_STEPS-1:0] bin_q;
  logic [19:0]           bcd_q;
  logic [CntW-1:0]       cnt_q;
  logic                  err_q;
  logic                  pend_src_q;
  logic                  src_q;
  logic                  done_q;
  logic [7:0]            sw_shown_q;
  logic [19:0]           dig_q;

  logic [19:0] bcd_adj;
  logic        ovf;
  logic        sw_req;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign ovf    = out_data_i > MAX_DEC;
  // Refresh when switches are not yet shown or their value differs from what is shown.
  assign sw_req = in_mode_i && (!src_q || (chaves_i != sw_shown_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      pend_src_q <= 1'b0;
      src_q      <= 1'b0;
      done_q     <= 1'b0;
      sw_shown_q <= '0;
      dig_q      <= 20'hFFFFF;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (out_valid_i) begin
            pend_src_q <= 1'b0;
            if (ovf) begin
              err_q   <= 1'b1;
              state_q <= StCommit;
            end else begin
              bin_q   <= out_data_i[CONV_STEPS-1:0];
              bcd_q   <= '0;
              cnt_q   <= '0;
              state_q <= StConv;
            end
          end else if (sw_req) begin
            sw_shown_q <= chaves_i;
            bin_q      <= {{(CONV_STEPS-8){1'b0}}, chaves_i};
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_src_q <= 1'b1;
            state_q    <= StConv;
          end
        end
        StConv: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(CONV_STEPS - 1)) begin
            state_q <= StCommit;
          end
        end
        StCommit: begin
          dig_q   <= err_q ? 20'hEEEEE : bcd_q;
          src_q   <= pend_src_q;
          err_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign src_o       = src_q;
  assign dig1_o      = dig_q[3:0];
  assign dig2_o      = dig_q[7:4];
  assign dig3_o      = dig_q[11:8];
  assign dig4_o      = dig_q[15:12];
  assign dig5_o      = dig_q[19:16];

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler with a latency/decimal reference model
// and directed literal checks of the key scenarios.
module tb_display_scheduler;

  logic        clk;
  logic        rst_n;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        in_mode;
  logic [7:0]  chaves;
  logic        busy;
  logic        done;
  logic        src;
  logic [3:0]  dig1, dig2, dig3, dig4, dig5;
  logic [19:0] dig_all;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  display_scheduler dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .out_valid_i(out_valid),
    .out_data_i (out_data),
    .out_ready_o(out_ready),
    .in_mode_i  (in_mode),
    .chaves_i   (chaves),
    .busy_o     (busy),
    .done_o     (done),
    .src_o      (src),
    .dig1_o     (dig1),
    .dig2_o     (dig2),
    .dig3_o     (dig3),
    .dig4_o     (dig4),
    .dig5_o     (dig5)
  );

  assign dig_all = {dig5, dig4, dig3, dig2, dig1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, most significant nibble = ten-thousands.
  function automatic logic [19:0] to_bcd(input logic [31:0] v);
    logic [19:0] r;
    int unsigned div;
    r   = '0;
    div = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div         = div * 10;
    end
    return r;
  endfunction

  // Reference model: cycles left until the commit edge, pending display, shown display.
  int          m_rem   = 0;
  logic [19:0] m_pend  = '0;
  logic        m_psrc  = 1'b0;
  logic [19:0] m_dig   = 20'hFFFFF;
  logic        m_src   = 1'b0;
  logic        m_done  = 1'b0;
  logic [7:0]  m_sw    = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_rem  = 0;
        m_dig  = 20'hFFFFF;
        m_src  = 1'b0;
        m_done = 1'b0;
        m_sw   = '0;
      end else begin
        m_done = 1'b0;
        if (m_rem == 0) begin
          if (out_valid) begin
            m_psrc = 1'b0;
            if (out_data > 32'd99999) begin
              m_pend = 20'hEEEEE;
              m_rem  = 1;
            end else begin
              m_pend = to_bcd(out_data);
              m_rem  = 18;
            end
          end else if (in_mode && (!m_src || chaves != m_sw)) begin
            m_sw   = chaves;
            m_pend = to_bcd({24'd0, chaves});
            m_psrc = 1'b1;
            m_rem  = 18;
          end
        end else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_dig  = m_pend;
            m_src  = m_psrc;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      chk("model_ready", out_ready, m_rem == 0);
      chk("model_busy", busy, m_rem != 0);
      chk("model_done", done, m_done);
      chk("model_src", src, m_src);
      chk("model_digits", dig_all, m_dig);
    end
  end

  // Present a value and hold it until the handshake edge; called at a negedge.
  task automatic write(input logic [31:0] v);
    bit ok;
    int n;
    out_valid = 1'b1;
    out_data  = v;
    ok        = 0;
    n         = 0;
    while (!ok && n < 100) begin
      if (out_ready) ok = 1;
      @(negedge clk);
      n++;
    end
    out_valid = 1'b0;
    chk("handshake_seen", ok, 1);
  endtask

  task automatic wait_done(output int n);
    bit got;
    got = 0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    rst_n     = 1'b1;
    out_valid = 1'b0;
    out_data  = '0;
    in_mode   = 1'b0;
    chaves    = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", dig_all, 20'hFFFFF);
    chk("rst_ready", out_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_src", src, 0);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    write(32'd12345);
    wait_done(lat);
    chk("lat_12345", lat, 18);
    chk("dig_12345", dig_all, 20'h12345);
    chk("src_12345", src, 0);
    @(negedge clk);
    chk("done_single", done, 0);

    write(32'd99999);
    wait_done(lat);
    chk("lat_99999", lat, 18);
    chk("dig_99999", dig_all, 20'h99999);
    write(32'd100000);
    wait_done(lat);
    chk("lat_100000", lat, 1);
    chk("dig_100000", dig_all, 20'hEEEEE);
    write(32'd0);
    wait_done(lat);
    chk("dig_0", dig_all, 20'h00000);
    write(32'hFFFFFFFF);
    wait_done(lat);
    chk("dig_ffffffff", dig_all, 20'hEEEEE);

    in_mode = 1'b1;
    chaves  = 8'd200;
    wait_done(lat);
    chk("dig_sw200", dig_all, 20'h00200);
    chk("src_sw200", src, 1);
    chaves = 8'd7;
    wait_done(lat);
    chk("dig_sw7", dig_all, 20'h00007);
    count_done(40, cnt);
    chk("sw_steady_no_done", cnt, 0);

    chaves = 8'd9;
    write(32'd42);
    wait_done(lat);
    chk("dig_simul_42", dig_all, 20'h00042);
    chk("src_simul_42", src, 0);
    wait_done(lat);
    chk("dig_simul_9", dig_all, 20'h00009);
    chk("src_simul_9", src, 1);

    chaves = 8'd3;
    @(negedge clk);
    write(32'd555);
    wait_done(lat);
    chk("dig_held_555", dig_all, 20'h00555);
    wait_done(lat);
    chk("dig_sw3", dig_all, 20'h00003);
    in_mode = 1'b0;
    count_done(25, cnt);
    chk("hold_no_done", cnt, 0);
    chk("hold_dig_3", dig_all, 20'h00003);
    chk("hold_src", src, 1);

    write(32'd54321);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midconv_dig", dig_all, 20'hFFFFF);
    chk("midconv_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_done(30, cnt);
    chk("midconv_no_done", cnt, 0);
    chk("midconv_dig_after", dig_all, 20'hFFFFF);
    write(32'd7);
    wait_done(lat);
    chk("dig_after_rst_7", dig_all, 20'h00007);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          case ($urandom_range(0, 4))
            0: write(32'($urandom_range(0, 99999)));
            1: write(32'd99999);
            2: write(32'd100000);
            3: write($urandom);
            default: write(32'($urandom_range(0, 255)));
          endcase
        end
        3, 4: begin
          in_mode = ~in_mode;
          @(negedge clk);
        end
        5, 6: begin
          chaves = 8'($urandom);
          @(negedge clk);
        end
        default: repeat ($urandom_range(1, 5)) @(negedge clk);
      endcase
    end
    repeat (25) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
